// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption controller: one shared round datapath, one round
// key fetched per cycle by index, IDLE/ROUND/FINAL/DONE sequencing.
module aes_enc_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] round_key,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext,
    output logic [3:0]   round
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    localparam logic [3:0] NR_W     = 4'(NR);
    localparam logic [3:0] LAST_MID = 4'(NR - 1);

    fsm_t         fsm_r, fsm_d;
    logic [127:0] state_r, state_d;
    logic [3:0]   round_r, round_d;
    logic [127:0] sr_s, mc_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] r;
        t = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3, t;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            t  = a0 ^ a1 ^ a2 ^ a3;
            o[127-32*c -: 8] = a0 ^ t ^ xtime(a0 ^ a1);
            o[119-32*c -: 8] = a1 ^ t ^ xtime(a1 ^ a2);
            o[111-32*c -: 8] = a2 ^ t ^ xtime(a2 ^ a3);
            o[103-32*c -: 8] = a3 ^ t ^ xtime(a3 ^ a0);
        end
        return o;
    endfunction

    // Shared round datapath; the final round taps off before MixColumns
    always_comb begin
        sr_s = shift_rows(sub_bytes(state_r));
        mc_s = mix_columns(sr_s);
    end

    // State, round counter and FSM registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r   <= IDLE;
            state_r <= 128'h0;
            round_r <= 4'd0;
        end else begin
            fsm_r   <= fsm_d;
            state_r <= state_d;
            round_r <= round_d;
        end
    end

    // Next-state and datapath selection
    always_comb begin
        fsm_d   = fsm_r;
        state_d = state_r;
        round_d = round_r;
        case (fsm_r)
            IDLE: begin
                if (start) begin
                    state_d = plaintext ^ round_key;
                    round_d = 4'd1;
                    fsm_d   = ROUND;
                end else begin
                    fsm_d   = IDLE;
                end
            end
            ROUND: begin
                state_d = mc_s ^ round_key;
                round_d = round_r + 4'd1;
                if (round_r == LAST_MID) fsm_d = FINAL;
                else                     fsm_d = ROUND;
            end
            FINAL: begin
                state_d = sr_s ^ round_key;
                fsm_d   = DONE;
            end
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered FSM state
    always_comb begin
        busy   = (fsm_r != IDLE);
        done   = (fsm_r == DONE);
        rk_idx = 4'd0;
        case (fsm_r)
            IDLE:    rk_idx = 4'd0;
            ROUND:   rk_idx = round_r;
            FINAL:   rk_idx = NR_W;
            DONE:    rk_idx = NR_W;
            default: rk_idx = 4'd0;
        endcase
    end

    assign ciphertext = state_r;
    assign round      = round_r;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Scoreboard bench for aes_enc_round_ctrl: byte-array AES reference model,
// cycle-count timing model, FIPS-197 vector and randomized blocks.
module tb_aes_enc_round_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] round_key;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
    logic [3:0]   round;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] rk_tab [0:10];
    logic [127:0] exp_q [$];

    int           total = 0;
    int           bad = 0;
    int           done_cnt = 0;
    int           cnt_m = 0;
    logic [3:0]   round_m = 4'd0;
    logic [127:0] ct_m = 128'h0;
    logic [127:0] cur_exp = 128'h0;

    aes_enc_round_ctrl #(.NR(10)) dut (
        .clk(clk), .rst(rst), .start(start), .plaintext(plaintext),
        .round_key(round_key), .rk_idx(rk_idx), .busy(busy), .done(done),
        .ciphertext(ciphertext), .round(round)
    );

    always #5 clk = ~clk;

    assign round_key = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : 128'h0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mul2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        return mul2(x) ^ x;
    endfunction

    // S-box table from the generator-3 walk over GF(2^8)
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rcon, 24'h0};
                rcon = mul2(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [7:0]   a [0:15];
        logic [7:0]   b [0:15];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = pt[127-8*i -: 8] ^ rk_tab[0][127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    b[r+4*c] = sbox_t[a[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    a[4*c]   = mul2(b[4*c]) ^ mul3(b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
                    a[4*c+1] = b[4*c] ^ mul2(b[4*c+1]) ^ mul3(b[4*c+2]) ^ b[4*c+3];
                    a[4*c+2] = b[4*c] ^ b[4*c+1] ^ mul2(b[4*c+2]) ^ mul3(b[4*c+3]);
                    a[4*c+3] = mul3(b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ mul2(b[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) a[4*c+r] = b[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) a[i] = a[i] ^ rk_tab[rnd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = a[i];
        return res;
    endfunction

    // Timing model: a block occupies 11 busy cycles after acceptance; issue side of the scoreboard
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_m   <= 0;
            round_m <= 4'd0;
            ct_m    <= 128'h0;
            exp_q.delete();
        end else if (cnt_m == 0) begin
            if (start) begin
                cur_exp <= ref_encrypt(plaintext);
                exp_q.push_back(ref_encrypt(plaintext));
                cnt_m   <= 11;
                round_m <= 4'd1;
            end
        end else begin
            cnt_m <= cnt_m - 1;
            if (round_m < 4'd10) round_m <= round_m + 4'd1;
            if (cnt_m == 2) ct_m <= cur_exp;
        end
    end

    // Monitor: per-cycle control checks plus result pop on every done pulse
    always @(negedge clk) begin
        chk("busy", {127'h0, busy}, {127'h0, cnt_m != 0});
        chk("done", {127'h0, done}, {127'h0, cnt_m == 1});
        chk("rk_idx", {124'h0, rk_idx}, {124'h0, (cnt_m == 0) ? 4'd0 : round_m});
        chk("round", {124'h0, round}, {124'h0, round_m});
        if (cnt_m <= 1) chk("ct_hold", ciphertext, ct_m);
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) chk("unexpected_done", 128'h1, 128'h0);
            else chk("ciphertext", ciphertext, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && cnt_m != 0; i++) step();
        if (cnt_m != 0) chk("idle_timeout", 128'h1, 128'h0);
    endtask

    initial begin
        int d0;
        logic [127:0] pt;
        rst = 1'b1;
        start = 1'b0;
        plaintext = 128'h0;
        build_sbox();
        expand_key(FIPS_KEY);
        chk("fips_rk10", rk_tab[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        repeat (2) step();
        chk("rst_ct", ciphertext, 128'h0);
        chk("rst_busy", {127'h0, busy}, 128'h0);
        rst = 1'b0;
        step();

        // FIPS-197 vector with intermediate states
        plaintext = FIPS_PT;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("edge0_ct", ciphertext, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        chk("edge0_round", {124'h0, round}, 128'h1);
        step();
        chk("edge1_ct", ciphertext, 128'ha49c7ff2689f352b6b5bea43026a5049);
        repeat (9) step();
        chk("fips_done", {127'h0, done}, 128'h1);
        chk("fips_ct", ciphertext, FIPS_CT);
        wait_idle();

        // Start pulse mid-block is ignored
        d0 = done_cnt;
        plaintext = FIPS_PT;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        chk("ignored_ct", ciphertext, FIPS_CT);
        chk("ignored_dones", 128'(done_cnt - d0), 128'd1);

        // start held high: one block every 12 cycles
        d0 = done_cnt;
        plaintext = FIPS_PT;
        start = 1'b1;
        repeat (36) step();
        start = 1'b0;
        wait_idle();
        chk("held_dones", 128'(done_cnt - d0), 128'd3);

        // Asynchronous reset in round 6
        expand_key({$urandom, $urandom, $urandom, $urandom});
        plaintext = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        #1;
        chk("arst_ct", ciphertext, 128'h0);
        chk("arst_busy", {127'h0, busy}, 128'h0);
        chk("arst_done", {127'h0, done}, 128'h0);
        chk("arst_rk", {124'h0, rk_idx}, 128'h0);
        chk("arst_round", {124'h0, round}, 128'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        step();
        pt = {$urandom, $urandom, $urandom, $urandom};
        plaintext = pt;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        chk("post_rst_ct", ciphertext, ref_encrypt(pt));

        // Randomized blocks with spurious start pulses while busy
        for (int n = 0; n < 6; n++) begin
            expand_key({$urandom, $urandom, $urandom, $urandom});
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            start = 1'b1;
            step();
            start = 1'b0;
            repeat ($urandom_range(0, 8)) step();
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            start = 1'b1;
            step();
            start = 1'b0;
            wait_idle();
            repeat ($urandom_range(0, 3)) step();
        end

        // Result hold with start low
        repeat (20) step();
        chk("hold_ct", ciphertext, ct_m);
        chk("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_enc_round_ctrl.md
# aes_enc_round_ctrl

Iterative AES-128 encryption controller. It accepts one plaintext block per request and reuses a single combinational round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey) over successive clock cycles, fetching one round key per cycle from an external round-key store. It sits between the host-side block interface and the existing combinational transform modules (SubBytes, ShiftRows, MixColumns; 128-bit in/out). It owns the state register, the round counter and the request/done handshake.

## Interface
- NR, 10, number of rounds. Only 10 (AES-128) is required to be supported.
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- plaintext  input  128  input block, sampled on the accepting edge
- round_key  input  128  round key selected by rk_idx; combinational (asynchronous-read) store
- rk_idx  output  4  round-key index requested this cycle, 0..NR
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; ciphertext valid
- ciphertext  output  128  direct view of the state register
- round  output  4  current round counter (debug)

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE: rk_idx=0. If start=1: state ← plaintext ^ round_key; round ← 1; go to ROUND. Otherwise hold all registers.
- ROUND: rk_idx=round. state ← MixColumns(ShiftRows(SubBytes(state))) ^ round_key; round ← round+1. Go to FINAL when round==NR-1 on this edge, else stay in ROUND.
- FINAL: rk_idx=NR. state ← ShiftRows(SubBytes(state)) ^ round_key (no MixColumns); go to DONE.
- DONE: done=1; state holds; round holds at NR; next state is IDLE unconditionally.
- start outside IDLE is ignored, including start in DONE; it is not queued.
- ciphertext holds the final result through IDLE until the next accepted start overwrites the state.
- rk_idx is a pure function of the FSM state and round; round_key is consumed in the same cycle.
- Byte order: bit 127..120 is state byte 0 (row 0, col 0), column-major. This matches the existing transform modules.
- Round counter is 4 bits and never wraps: max value NR=10.

## Timing
- Reset (asynchronous, any state, including mid-block): state=0, round=0, FSM=IDLE, busy=0, done=0, rk_idx=0, ciphertext=0. The in-flight block is discarded, with no done pulse.
- Accepting edge is edge 0. Edges 1..9 perform rounds 1..9. Edge 10 performs the final round. done is high in the cycle after edge 10, for exactly one cycle.
- Latency from start sample to done: 11 cycles. Minimum start-to-start spacing: 12 cycles (DONE → IDLE → accept).
- busy rises after edge 0 and falls after the DONE cycle. busy and done are both high in the DONE cycle.
- rk_idx sequence per block: 0 (IDLE accept), 1..9, 10, then 10 held in DONE (don't-care), then 0.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, bench supplies the expanded schedule by rk_idx. Required: ciphertext 3925841d02dc09fbdc118597196a0b32 with done at cycle 11.
- Intermediate checks on the same vector:
  - after edge 0, ciphertext=193de3bea0f4e22b9ac68d2ae9f84808 and round=1;
  - after edge 1, ciphertext=a49c7ff2689f352b6b5bea43026a5049.
- Handshake: hold start=1 continuously. Required:
  - exactly one done pulse per 12 cycles;
  - rk_idx follows 0,1..10,10,0 each period;
  - busy is low only in the IDLE cycle.
- Start ignored while busy: pulse start with a different plaintext at cycle 5. Required: result is still 3925841d...0b32 and no extra done.
- Reset mid-operation: assert rst asynchronously (between edges) at round 6. Required:
  - all outputs immediately 0, no done pulse;
  - after release, a new start yields correct ciphertext 11 cycles later.
- Result hold: after done, keep start=0 for 20 cycles. Required: ciphertext stable at the result, busy=0, done=0.
